// File: rtl/i2c_regfile_target.sv
// I2C target with a byte-wide register file, auto-incrementing sub-address pointer
// and per-register read-only status mapping.
module i2c_regfile_target #(
  parameter logic [6:0]          I2C_ADDR    = 7'h70,
  parameter int                  NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [7:0]          RST_VAL     = 8'h00,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sda_in,
  input  logic                  scl_in,
  output logic                  sda_out,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_out,
  input  logic [NUM_REGS*8-1:0] status_in,
  output logic [NUM_REGS-1:0]   wr_strobe,
  output logic                  busy
);
  localparam int SUB_W = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d, scl_sync_q, scl_sync_d;
  logic                   sda_hist_q, scl_hist_q;
  logic                   sda_s, scl_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [SUB_W-1:0]       ptr_q, ptr_d, ptr_inc;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic [NUM_REGS*8-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
  logic [7:0]             rd_cur, rd_next;

  // Synchronisers reset to the idle bus level so reset release never fakes an edge
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  assign ptr_inc = ptr_q + SUB_W'(1);
  assign rd_cur  = RO_MASK[ptr_q]   ? status_in[{ptr_q, 3'b000} +: 8]   : regs_q[{ptr_q, 3'b000} +: 8];
  assign rd_next = RO_MASK[ptr_inc] ? status_in[{ptr_inc, 3'b000} +: 8] : regs_q[{ptr_inc, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, SUB, WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                ADDR: begin
                  if (shift_d[7:1] == I2C_ADDR) begin
                    rw_d    = shift_d[0];
                    state_d = ADDR_ACK;
                  end else begin
                    state_d = IDLE;
                  end
                end
                SUB: begin
                  ptr_d   = shift_d[SUB_W-1:0];
                  state_d = SUB_ACK;
                end
                default: begin
                  if (!RO_MASK[ptr_q]) begin
                    regs_d[{ptr_q, 3'b000} +: 8] = shift_d;
                    wr_strobe_d[ptr_q]           = 1'b1;
                  end
                  ptr_d   = ptr_inc;
                  state_d = WDATA_ACK;
                end
              endcase
            end
          end
        end
        // First falling edge starts driving the ACK, the second one ends it
        ADDR_ACK, SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_d  = rd_cur;
                sda_oe_d = ~rd_cur[7];
                state_d  = RDATA;
              end else if (state_q == ADDR_ACK) begin
                state_d = SUB;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        // cnt 0 on a falling edge means the byte was loaded after a master ACK
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = RDATA_ACK;
            end else if (cnt_q == 4'd0) begin
              sda_oe_d = ~shift_q[7];
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IDLE;
            end else begin
              ptr_d   = ptr_inc;
              shift_d = rd_next;
              cnt_d   = 4'd0;
              state_d = RDATA;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sync_q  <= '1;
      scl_sync_q  <= '1;
      sda_hist_q  <= 1'b1;
      scl_hist_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'd0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      regs_q      <= {NUM_REGS{RST_VAL}};
      wr_strobe_q <= '0;
    end else begin
      sda_sync_q  <= sda_sync_d;
      scl_sync_q  <= scl_sync_d;
      sda_hist_q  <= sda_s;
      scl_hist_q  <= scl_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign sda_out   = 1'b0;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
endmodule

// File: tb/tb_i2c_regfile_target.sv
// Bus-master bench for i2c_regfile_target: directed transactions with a scoreboard
// of expected register writes and read bytes.
`timescale 1ns/1ps
module tb_i2c_regfile_target;
  localparam int NUM_REGS = 16;
  localparam int Q        = 100;
  localparam logic [7:0] RST_VAL = 8'h3C;
  localparam int OP_START = 0, OP_STOP = 1, OP_WRITE = 2, OP_READ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;
  logic sda_out, sda_oe, busy;
  logic [NUM_REGS*8-1:0] regs_out, status_in;
  logic [NUM_REGS-1:0]   wr_strobe;
  logic sda_bus;

  assign sda_bus = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_regfile_target #(
    .I2C_ADDR(7'h70), .NUM_REGS(NUM_REGS), .RO_MASK(16'h0004),
    .RST_VAL(RST_VAL), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .sda_in(sda_bus), .scl_in(m_scl),
    .sda_out(sda_out), .sda_oe(sda_oe), .regs_out(regs_out),
    .status_in(status_in), .wr_strobe(wr_strobe), .busy(busy)
  );

  typedef struct {
    logic       is_read;
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_regs [NUM_REGS];
  int         rd_seq = 0;
  int         rd_seen = 0;
  logic [7:0] rd_data = 8'h00;
  logic       watch_oe = 1'b0;
  logic       oe_seen = 1'b0;
  logic [7:0] dummy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic checkRegs(input string name);
    for (int i = 0; i < NUM_REGS; i++)
      checkOutput($sformatf("%s_reg%0d", name, i), 32'(regs_out[i*8 +: 8]), 32'(exp_regs[i]));
  endtask

  task automatic expectWrite(input int idx, input logic [7:0] data);
    sb_q.push_back('{1'b0, idx, data});
    exp_regs[idx] = data;
  endtask

  task automatic expectRead(input logic [7:0] data);
    sb_q.push_back('{1'b1, 0, data});
  endtask

  // Scoreboard monitor: every strobe cycle and every byte the master reads pops one entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wr_strobe != '0) begin
      checks++;
      if (sb_q.size() == 0 || sb_q[0].is_read) begin
        failures++;
        $display("[TB] FAIL unexpected_strobe actual=0x%0h required=none", wr_strobe);
      end else begin
        e = sb_q.pop_front();
        if (wr_strobe !== 16'(1 << e.idx) || regs_out[e.idx*8 +: 8] !== e.data) begin
          failures++;
          $display("[TB] FAIL write_reg%0d actual strobe=0x%0h data=0x%0h required strobe=0x%0h data=0x%0h",
                   e.idx, wr_strobe, regs_out[e.idx*8 +: 8], 16'(1 << e.idx), e.data);
        end
      end
    end
    if (rd_seq != rd_seen) begin
      rd_seen = rd_seq;
      checks++;
      if (sb_q.size() == 0 || !sb_q[0].is_read) begin
        failures++;
        $display("[TB] FAIL unexpected_read actual=0x%0h required=none", rd_data);
      end else begin
        e = sb_q.pop_front();
        if (rd_data !== e.data) begin
          failures++;
          $display("[TB] FAIL read_byte actual=0x%0h required=0x%0h", rd_data, e.data);
        end
      end
    end
    if (watch_oe && sda_oe) oe_seen = 1'b1;
  end

  // One bus operation; for WRITE exp_bit is the expected ACK level, for READ the master's ACK/NAK
  task automatic applyStimulus(input int op, input logic [7:0] data, input logic exp_bit, input string name);
    logic [7:0] b;
    logic       ack;
    case (op)
      OP_START: begin
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
      end
      OP_STOP: begin
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
      end
      OP_WRITE: begin
        for (int i = 7; i >= 0; i--) begin
          m_sda = data[i]; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; ack = sda_bus; #Q; m_scl = 1'b0; #Q;
        checkOutput(name, 32'(ack), 32'(exp_bit));
      end
      default: begin
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
          #Q; m_scl = 1'b1; #Q; b[i] = sda_bus; #Q; m_scl = 1'b0; #Q;
        end
        rd_data = b;
        rd_seq++;
        m_sda = exp_bit; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
      end
    endcase
  endtask

  task automatic basicWrite(input string p);
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE0, 1'b0, {p, "_addr_ack"});
    checkOutput({p, "_busy_mid"}, 32'(busy), 32'd1);
    applyStimulus(OP_WRITE, 8'h0A, 1'b0, {p, "_sub_ack"});
    expectWrite(10, 8'h55);
    applyStimulus(OP_WRITE, 8'h55, 1'b0, {p, "_data0_ack"});
    expectWrite(11, 8'h1F);
    applyStimulus(OP_WRITE, 8'h1F, 1'b0, {p, "_data1_ack"});
    applyStimulus(OP_STOP, 8'h00, 1'b0, "stop");
    checkOutput({p, "_busy_after_stop"}, 32'(busy), 32'd0);
    checkRegs(p);
  endtask

  initial begin
    status_in = {NUM_REGS{8'hEE}};
    status_in[23:16] = 8'hA5;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RST_VAL;

    // Reset state
    #50;
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_strobe", 32'(wr_strobe), 32'd0);
    checkOutput("rst_sda_out", 32'(sda_out), 32'd0);
    #50; rst = 1'b0; #(2*Q);
    checkRegs("rst");

    // Basic write
    basicWrite("t1");

    // Sub-address 127 wraps into 15, then the pointer wraps to 0
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE0, 1'b0, "t2_addr_ack");
    applyStimulus(OP_WRITE, 8'h7F, 1'b0, "t2_sub_ack");
    expectWrite(15, 8'hFA);
    applyStimulus(OP_WRITE, 8'hFA, 1'b0, "t2_data0_ack");
    expectWrite(0, 8'h4D);
    applyStimulus(OP_WRITE, 8'h4D, 1'b0, "t2_data1_ack");
    applyStimulus(OP_STOP, 8'h00, 1'b0, "stop");
    checkRegs("t2");

    // Read three bytes through a repeated START
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE0, 1'b0, "t3_addr_ack");
    applyStimulus(OP_WRITE, 8'h0E, 1'b0, "t3_sub_ack");
    applyStimulus(OP_START, 8'h00, 1'b0, "rstart");
    applyStimulus(OP_WRITE, 8'hE1, 1'b0, "t3_raddr_ack");
    expectRead(RST_VAL);
    applyStimulus(OP_READ, 8'h00, 1'b0, "t3_rd0");
    expectRead(8'hFA);
    applyStimulus(OP_READ, 8'h00, 1'b0, "t3_rd1");
    expectRead(8'h4D);
    applyStimulus(OP_READ, 8'h00, 1'b1, "t3_rd2");
    checkOutput("t3_sda_oe_after_nak", 32'(sda_oe), 32'd0);
    applyStimulus(OP_STOP, 8'h00, 1'b0, "stop");
    checkOutput("t3_busy_after_stop", 32'(busy), 32'd0);

    // Wrong address is ignored entirely
    oe_seen = 1'b0;
    watch_oe = 1'b1;
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE2, 1'b1, "t4_addr_nak");
    applyStimulus(OP_WRITE, 8'h05, 1'b1, "t4_byte0_nak");
    applyStimulus(OP_WRITE, 8'h99, 1'b1, "t4_byte1_nak");
    checkOutput("t4_busy_idle", 32'(busy), 32'd0);
    applyStimulus(OP_STOP, 8'h00, 1'b0, "stop");
    watch_oe = 1'b0;
    checkOutput("t4_oe_never", 32'(oe_seen), 32'd0);
    checkRegs("t4");

    // Read-only register: write is ACKed but dropped, read returns the status byte
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE0, 1'b0, "t5_addr_ack");
    applyStimulus(OP_WRITE, 8'h02, 1'b0, "t5_sub_ack");
    applyStimulus(OP_WRITE, 8'h00, 1'b0, "t5_ro_data_ack");
    applyStimulus(OP_STOP, 8'h00, 1'b0, "stop");
    checkRegs("t5");
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE0, 1'b0, "t5_addr2_ack");
    applyStimulus(OP_WRITE, 8'h02, 1'b0, "t5_sub2_ack");
    applyStimulus(OP_START, 8'h00, 1'b0, "rstart");
    applyStimulus(OP_WRITE, 8'hE1, 1'b0, "t5_raddr_ack");
    expectRead(8'hA5);
    applyStimulus(OP_READ, 8'h00, 1'b1, "t5_rd");
    applyStimulus(OP_STOP, 8'h00, 1'b0, "stop");

    // Reset during the 4th bit of a data byte
    applyStimulus(OP_START, 8'h00, 1'b0, "start");
    applyStimulus(OP_WRITE, 8'hE0, 1'b0, "t6_addr_ack");
    applyStimulus(OP_WRITE, 8'h05, 1'b0, "t6_sub_ack");
    dummy = 8'hB6;
    for (int i = 7; i >= 5; i--) begin
      m_sda = dummy[i]; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    end
    m_sda = dummy[4]; #Q; m_scl = 1'b1; #Q;
    checkOutput("t6_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    checkOutput("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = RST_VAL;
    checkRegs("t6_rst");
    #(Q-2);
    m_scl = 1'b0; #Q; m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
    rst = 1'b0; #(4*Q);
    basicWrite("t6");

    #(4*Q);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_regfile_target.md
# i2c_regfile_target

Parametrised I2C target (slave) with an internal byte-wide register file, sub-address pointer with auto-increment/wrap, and per-register read-only status mapping. It sits between the shared uio SDA/SCL pins and the dice/display logic, which use it for configuration and result read-back. It is the generalised successor of the fixed-address I2C slave in the dice project and supports configurable address, depth, reset contents and a status-register mask.

## Interface
- `I2C_ADDR`, 7'h70: 7-bit target address.
- `NUM_REGS`, 16: register count; must be a power of two, 2..128. `SUB_W = log2(NUM_REGS)`.
- `RO_MASK`, 0: `NUM_REGS`-bit mask. A bit set to 1 makes that register read-only; its value comes from `status_in`.
- `RST_VAL`, 0: 8-bit reset value for every writable register.
- `SYNC_STAGES`, 2: number of input synchroniser flops, 2..3.
- Ports:
  - `clk`, in, 1: system clock. Must run ≥ 10× the SCL frequency.
  - `rst`, in, 1: reset, asynchronous and active-high.
  - `sda_in`, in, 1: SDA pin, resolved level.
  - `scl_in`, in, 1: SCL pin, resolved level.
  - `sda_out`, out, 1: constant 0 (open-drain).
  - `sda_oe`, out, 1: 1 pulls SDA low.
  - `regs_out`, out, `NUM_REGS*8`: register file, flat. Register n is at `[8n+7:8n]`.
  - `status_in`, in, `NUM_REGS*8`: read-only sources, same layout. Only bytes whose `RO_MASK` bit is set are used.
  - `wr_strobe`, out, `NUM_REGS`: one-cycle pulse per register written.
  - `busy`, out, 1: high from START until STOP or return to IDLE.

## Operation
- **Input conditioning.** SDA and SCL each pass through `SYNC_STAGES` flops plus one history flop. Edge and START/STOP detection use only the synchronised signals.
- **Bus conditions** (both checked on every clk, from any state):
  - START or repeated START: SDA falls while SCL is high. Clear the bit counter and go to ADDR.
  - STOP: SDA rises while SCL is high. Go to IDLE and release SDA.
- **Sampling and driving.** Data is sampled on detected SCL rising edges. SDA is changed only on detected SCL falling edges.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If the upper 7 bits equal `I2C_ADDR`, go to ADDR_ACK.
    - Otherwise go to IDLE without driving SDA (NAK).
  - ADDR_ACK: drive 0 for one SCL pulse.
    - R/W = 0: go to SUB.
    - R/W = 1: load the read byte and go to RDATA.
  - SUB: shift 8 bits. Pointer ← byte mod `NUM_REGS`. Then go to SUB_ACK.
  - SUB_ACK: drive 0 for one pulse, then go to WDATA.
  - WDATA: shift 8 bits.
    - If `RO_MASK[ptr]` = 0: write `regs_out[ptr]` and pulse `wr_strobe[ptr]`.
    - If `RO_MASK[ptr]` = 1: discard the byte, no strobe.
    - In both cases: ptr ← ptr+1 mod `NUM_REGS`, then go to WDATA_ACK.
  - WDATA_ACK: drive 0 for one pulse, then go to WDATA. Unlimited bytes.
  - RDATA: shift out MSB first, then go to RDATA_ACK. SDA is released during the master ACK bit.
  - RDATA_ACK: sample the master's bit.
    - ACK (0): ptr++ with wrap, load the next byte, go to RDATA.
    - NAK (1): go to IDLE.
- **Read source.** The read byte is `status_in[ptr]` if `RO_MASK[ptr]` is set, else `regs_out[ptr]`. It is captured at load time.
- **Pointer persistence.** The pointer survives STOP and repeated START, so a read continues from the last written sub-address or auto-increment position.
- **Reset.** Async `rst` forces state IDLE, `sda_oe` = 0, `wr_strobe` = 0, `busy` = 0, ptr = 0, writable registers = `RST_VAL`. This applies even mid-transfer. The first transaction after `rst` deasserts must complete normally.

## Timing
- Detection latency from a pin transition to its internal edge event: `SYNC_STAGES`+1 clk.
- `sda_oe` changes 1 clk after a detected SCL falling edge.
- ACK/NAK release happens on the detected SCL falling edge that ends the ACK bit.
- The `regs_out` update and the `wr_strobe` pulse occur in the same clk, 1 clk after the 8th data bit's SCL rising edge is detected.
- A START or STOP that arrives in the same clk as an SCL edge takes priority. The SCL edge is ignored.
- `busy` rises 1 clk after START is detected. It falls 1 clk after STOP is detected, or on entry to IDLE after a NAK or address mismatch.

## Test plan
1. **Basic write.** Write to 0x70, sub 10, data 0x55 then 0x1F, then STOP.
   - All 4 bytes ACKed.
   - reg10 = 0x55, reg11 = 0x1F.
   - `wr_strobe[10]` then `wr_strobe[11]`, one pulse each.
2. **Wrap-around.** Sub 127 with `NUM_REGS` = 16, data 0xFA then 0x4D.
   - ptr = 15, so reg15 = 0xFA.
   - Wrap gives reg0 = 0x4D.
3. **Read with repeated START.** Write sub 14, repeated START, read 3 bytes with master ACK, ACK, NAK.
   - Returns `RST_VAL`, then 0xFA, then 0x4D.
   - `sda_oe` = 0 after the NAK.
   - The following STOP drops `busy`.
4. **Wrong address.** Address 0x71 followed by 2 bytes.
   - `sda_oe` never asserts.
   - Registers and strobes unchanged.
   - State returns to IDLE until the next START.
5. **Read-only register.** `RO_MASK` bit 2 set, `status_in` byte 2 = 0xA5.
   - Write 0x00 to sub 2: ACKed, reg2 is not modified, no strobe.
   - Read back sub 2: returns 0xA5.
6. **Reset mid-transfer.** Assert `rst` during the 4th bit of a data byte.
   - `sda_oe` = 0 and `busy` = 0 immediately.
   - Registers = `RST_VAL`.
   - After release, a test 1 transaction succeeds.
